// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - SCL/SDA synchroniser, 5-sample majority filter, edge and START/STOP detect
module generic__maj5 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    input  logic e_i,
    output logic y_o
);
    assign y_o = (a_i & b_i & c_i) | (a_i & b_i & d_i) | (a_i & b_i & e_i) |
                 (a_i & c_i & d_i) | (a_i & c_i & e_i) | (a_i & d_i & e_i) |
                 (b_i & c_i & d_i) | (b_i & c_i & e_i) | (b_i & d_i & e_i) |
                 (c_i & d_i & e_i);
endmodule

module i2c_line_filter #(
    parameter int PRESCALE_W  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  scl_rise,
    output logic                  scl_fall,
    output logic                  sda_rise,
    output logic                  sda_fall,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  sample_stb
);
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [PRESCALE_W-1:0]  cnt_q, cnt_d;
    logic [4:0]             scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    logic                   scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic                   scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
    logic                   run_q;
    logic                   scl_vote, sda_vote;

    // Synchronisers free-run regardless of ena; reset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    // run_q keeps sample_stb quiet while reset is asserted without using rst_n as data.
    assign sample_stb = run_q & ena & (cnt_q >= prescale);

    generic__maj5 u_scl_maj (
        .a_i(scl_h_q[0]), .b_i(scl_h_q[1]), .c_i(scl_h_q[2]),
        .d_i(scl_h_q[3]), .e_i(scl_h_q[4]), .y_o(scl_vote)
    );
    generic__maj5 u_sda_maj (
        .a_i(sda_h_q[0]), .b_i(sda_h_q[1]), .c_i(sda_h_q[2]),
        .d_i(sda_h_q[3]), .e_i(sda_h_q[4]), .y_o(sda_vote)
    );

    always_comb begin
        cnt_d     = '0;
        scl_h_d   = scl_h_q;
        sda_h_d   = sda_h_q;
        scl_f_d   = scl_f_q;
        sda_f_d   = sda_f_q;
        scl_dly_d = scl_dly_q;
        sda_dly_d = sda_dly_q;
        if (!sample_stb && ena) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (sample_stb) begin
            scl_h_d = {scl_h_q[3:0], scl_sync_q[SYNC_STAGES-1]};
            sda_h_d = {sda_h_q[3:0], sda_sync_q[SYNC_STAGES-1]};
        end
        if (ena) begin
            scl_f_d   = scl_vote;
            sda_f_d   = sda_vote;
            scl_dly_d = scl_f_q;
            sda_dly_d = sda_f_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            scl_h_q   <= 5'b11111;
            sda_h_q   <= 5'b11111;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_dly_q <= 1'b1;
        end else begin
            run_q     <= 1'b1;
            cnt_q     <= cnt_d;
            scl_h_q   <= scl_h_d;
            sda_h_q   <= sda_h_d;
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_dly_q <= scl_dly_d;
            sda_dly_q <= sda_dly_d;
        end
    end

    // Strobes are gated by ena so a frozen f/d mismatch cannot repeat an edge.
    assign scl_o     = scl_f_q;
    assign sda_o     = sda_f_q;
    assign scl_rise  = ena &  scl_f_q & ~scl_dly_q;
    assign scl_fall  = ena & ~scl_f_q &  scl_dly_q;
    assign sda_rise  = ena &  sda_f_q & ~sda_dly_q;
    assign sda_fall  = ena & ~sda_f_q &  sda_dly_q;
    assign start_det = sda_fall & scl_f_q & scl_dly_q;
    assign stop_det  = sda_rise & scl_f_q & scl_dly_q;
endmodule
